tag_ram_arbiter: RTL and testbench

Sequencing and arbitration controller in front of a single-port, synchronous-read tag RAM: one address, one write enable, one read-data bus, with read data valid one cycle after the address. It clears every tag entry after reset. It then shares the RAM between a lookup requester (read and compare, producing hit/miss) and a fill requester (tag write). A lookup can be issued every cycle; the block sits between the cache controller and the tag RAM instance.

---
 rtl/tag_ram_arbiter_pkg.sv | 24 ++
 rtl/tag_ram_arbiter_if.sv | 68 ++++++
 rtl/tag_ram_arbiter_rr_arb2.sv | 45 ++++
 rtl/tag_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_tag_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tag_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tag_arb_pkg
// Shared types and constants for the tag RAM arbiter slice.
//   arb_state_e : controller FSM states (RST_WAIT, INIT, RUN)
//   STATS_W     : width of the optional hit/miss counters
//   valid_bit() : bit position of the valid flag inside a RAM word
// Optional feature macro used by the slice: TAG_ARB_STATS_EN
// -----------------------------------------------------------------------------
package tag_arb_pkg;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } arb_state_e;

    localparam int STATS_W = 16;

    // The valid flag sits directly above the tag bits in every RAM word.
    function automatic int valid_bit(input int twidth);
        return twidth;
    endfunction

endpackage

// File: rtl/tag_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// tag_ram_arbiter_if
// Bundles the lookup port, fill port, init status and tag RAM bus.
//   slave  : the arbiter (drives grants, lookup result, init_busy, RAM controls)
//   master : the cache controller plus RAM instance (drives requests, ram_dout)
// With TAG_ARB_STATS_EN defined, stats_clr, hit_cnt and miss_cnt are added.
// -----------------------------------------------------------------------------
interface tag_ram_arbiter_if #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 6
);
    import tag_arb_pkg::*;

    logic              lk_req;
    logic [AWIDTH-1:0] lk_index;
    logic [TWIDTH-1:0] lk_tag;
    logic              lk_gnt;
    logic              lk_done;
    logic              lk_hit;

    logic              fl_req;
    logic [AWIDTH-1:0] fl_index;
    logic [TWIDTH-1:0] fl_tag;
    logic              fl_valid;
    logic              fl_gnt;

    logic              init_busy;

    logic [AWIDTH-1:0] ram_addr;
    logic [TWIDTH:0]   ram_din;
    logic              ram_we;
    logic [TWIDTH:0]   ram_dout;

`ifdef TAG_ARB_STATS_EN
    logic               stats_clr;
    logic [STATS_W-1:0] hit_cnt;
    logic [STATS_W-1:0] miss_cnt;
`endif

    modport slave (
`ifdef TAG_ARB_STATS_EN
        input  stats_clr,
        output hit_cnt, miss_cnt,
`endif
        input  lk_req, lk_index, lk_tag,
        output lk_gnt, lk_done, lk_hit,
        input  fl_req, fl_index, fl_tag, fl_valid,
        output fl_gnt,
        output init_busy,
        output ram_addr, ram_din, ram_we,
        input  ram_dout
    );

    modport master (
`ifdef TAG_ARB_STATS_EN
        output stats_clr,
        input  hit_cnt, miss_cnt,
`endif
        output lk_req, lk_index, lk_tag,
        input  lk_gnt, lk_done, lk_hit,
        output fl_req, fl_index, fl_tag, fl_valid,
        input  fl_gnt,
        input  init_busy,
        input  ram_addr, ram_din, ram_we,
        output ram_dout
    );

endinterface

// File: rtl/tag_ram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a single-bit pointer.
//   clock, reset_n : clock and asynchronous active-low reset
//   run            : arbitration enabled (no grants while low)
//   req[1:0]       : requests, bit 0 = fill, bit 1 = lookup
//   gnt[1:0]       : one-hot grant, same bit order as req
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_q;
    logic rr_d;

    // A lone requester wins outright. On a conflict the pointer picks the
    // winner (0 = fill, 1 = lookup) and then flips so the loser wins next time,
    // which bounds every requester's wait to a single cycle.
    always_comb begin
        gnt  = 2'b00;
        rr_d = rr_q;
        if (run) begin
            if (req == 2'b11) begin
                gnt  = rr_q ? 2'b10 : 2'b01;
                rr_d = ~rr_q;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer register; starts out favouring the fill side.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/tag_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tag_ram_arbiter
// Sequencer/arbiter in front of a single-port, synchronous-read tag RAM.
// After reset it clears every entry, then shares the RAM between a lookup
// requester (read + tag compare) and a fill requester (tag write).
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : lookup port, fill port, init_busy and the tag RAM bus
// Optional feature: TAG_ARB_STATS_EN adds saturating hit/miss counters with
// a synchronous clear (stats_clr).
// -----------------------------------------------------------------------------
module tag_ram_arbiter
    import tag_arb_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    tag_ram_arbiter_if.slave  bus
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int VB    = valid_bit(TWIDTH);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [AWIDTH-1:0] sweepCnt_q;
    logic [AWIDTH-1:0] sweepCnt_d;
    logic [AWIDTH-1:0] lastAddr_q;
    logic              lkPend_q;
    logic [TWIDTH-1:0] lkTag_q;

    logic [1:0]        arbGnt;
    logic [AWIDTH-1:0] ramAddr;
    logic [TWIDTH:0]   ramDin;
    logic              ramWe;
    logic              lkHit;

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (state_q == RUN),
        .req     ({bus.lk_req, bus.fl_req}),
        .gnt     (arbGnt)
    );

    // Next-state and RAM mux. While idle the address bus keeps its last value
    // so the RAM sees no needless toggling; write data idles at zero.
    always_comb begin
        state_d    = state_q;
        sweepCnt_d = sweepCnt_q;
        ramAddr    = lastAddr_q;
        ramDin     = '0;
        ramWe      = 1'b0;
        case (state_q)
            RST_WAIT: begin
                state_d = INIT;
            end
            INIT: begin
                ramAddr = sweepCnt_q;
                ramWe   = 1'b1;
                if (sweepCnt_q == AWIDTH'(DEPTH - 1)) begin
                    state_d    = RUN;
                    sweepCnt_d = '0;
                end else begin
                    sweepCnt_d = sweepCnt_q + AWIDTH'(1);
                end
            end
            RUN: begin
                if (arbGnt[0]) begin
                    ramAddr = bus.fl_index;
                    ramDin  = {bus.fl_valid, bus.fl_tag};
                    ramWe   = 1'b1;
                end else if (arbGnt[1]) begin
                    ramAddr = bus.lk_index;
                end
            end
            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

    // State, sweep counter and the held RAM address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RST_WAIT;
            sweepCnt_q <= '0;
            lastAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepCnt_q <= sweepCnt_d;
            lastAddr_q <= ramAddr;
        end
    end

    // Lookup pipeline: remember the tag of a granted lookup so it can be
    // compared against the RAM word that appears one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lkPend_q <= 1'b0;
            lkTag_q  <= '0;
        end else begin
            lkPend_q <= arbGnt[1];
            if (arbGnt[1]) begin
                lkTag_q <= bus.lk_tag;
            end
        end
    end

    assign lkHit = lkPend_q && bus.ram_dout[VB] &&
                   (bus.ram_dout[TWIDTH-1:0] == lkTag_q);

    assign bus.fl_gnt    = arbGnt[0];
    assign bus.lk_gnt    = arbGnt[1];
    assign bus.lk_done   = lkPend_q;
    assign bus.lk_hit    = lkHit;
    assign bus.init_busy = (state_q != RUN);
    assign bus.ram_addr  = ramAddr;
    assign bus.ram_din   = ramDin;
    assign bus.ram_we    = ramWe;

`ifdef TAG_ARB_STATS_EN
    logic [STATS_W-1:0] hitCnt_q;
    logic [STATS_W-1:0] missCnt_q;

    // Saturating hit/miss counters; a clear in the same cycle as a completed
    // lookup takes priority and the lookup is not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (bus.stats_clr) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (lkPend_q) begin
            if (lkHit) begin
                if (hitCnt_q != '1) begin
                    hitCnt_q <= hitCnt_q + STATS_W'(1);
                end
            end else begin
                if (missCnt_q != '1) begin
                    missCnt_q <= missCnt_q + STATS_W'(1);
                end
            end
        end
    end

    assign bus.hit_cnt  = hitCnt_q;
    assign bus.miss_cnt = missCnt_q;
`endif

endmodule

// File: tb/tb_tag_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tag_ram_arbiter
// Directed bench for tag_ram_arbiter with a behavioural synchronous-read RAM.
// Honours TAG_ARB_STATS_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_tag_ram_arbiter;

    logic clock = 1'b0;
    logic reset_n;
    logic ramPreload;
    logic [6:0] mem [8];
    logic [6:0] ramDoutQ;
    int checkCount = 0;
    int failCount  = 0;

    tag_ram_arbiter_if #(.AWIDTH(3), .TWIDTH(6)) bus ();

    tag_ram_arbiter #(.AWIDTH(3), .TWIDTH(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Behavioural tag RAM: read returns the word stored before this edge's write.
    // Preload fills it with all-ones so the clear sweep is observable.
    always @(posedge clock) begin
        if (ramPreload) begin
            for (int i = 0; i < 8; i++) mem[i] <= 7'h7F;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
            ramDoutQ <= mem[bus.ram_addr];
        end
    end

    assign bus.ram_dout = ramDoutQ;

    // Advance to just after the next rising edge.
    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    // Drive both requester ports, then let the combinational outputs settle.
    task automatic applyStimulus(input logic lkReq, input logic [2:0] lkIdx,
                                 input logic [5:0] lkTag, input logic flReq,
                                 input logic [2:0] flIdx, input logic [5:0] flTag,
                                 input logic flValid);
        bus.lk_req   = lkReq;
        bus.lk_index = lkIdx;
        bus.lk_tag   = lkTag;
        bus.fl_req   = flReq;
        bus.fl_index = flIdx;
        bus.fl_tag   = flTag;
        bus.fl_valid = flValid;
        #1;
    endtask

    // Reset values, then the clear sweep and the RAM contents it leaves behind.
    task automatic test_reset;
        reset_n    = 1'b0;
        ramPreload = 1'b1;
        applyStimulus(1, 3'd1, 6'h00, 1, 3'd2, 6'h01, 1);
        repeat (2) nextCycle;
        ramPreload = 1'b0;
        checkCount++; if (bus.lk_done !== 1'b0) begin failCount++; $display("[TB] FAIL rst_lk_done got=%0h want=0", bus.lk_done); end
        checkCount++; if (bus.lk_hit !== 1'b0) begin failCount++; $display("[TB] FAIL rst_lk_hit got=%0h want=0", bus.lk_hit); end
        checkCount++; if ({bus.lk_gnt, bus.fl_gnt} !== 2'b00) begin failCount++; $display("[TB] FAIL rst_gnt got=%0b want=00", {bus.lk_gnt, bus.fl_gnt}); end
        checkCount++; if (bus.ram_we !== 1'b0) begin failCount++; $display("[TB] FAIL rst_ram_we got=%0h want=0", bus.ram_we); end
        checkCount++; if (bus.ram_addr !== 3'd0) begin failCount++; $display("[TB] FAIL rst_ram_addr got=%0h want=0", bus.ram_addr); end
        checkCount++; if (bus.ram_din !== 7'h00) begin failCount++; $display("[TB] FAIL rst_ram_din got=%0h want=0", bus.ram_din); end
        checkCount++; if (bus.init_busy !== 1'b1) begin failCount++; $display("[TB] FAIL rst_init_busy got=%0h want=1", bus.init_busy); end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        #1;
        checkCount++; if (bus.ram_we !== 1'b0) begin failCount++; $display("[TB] FAIL rstwait_ram_we got=%0h want=0", bus.ram_we); end
        for (int i = 0; i < 8; i++) begin
            nextCycle;
            checkCount++; if ({bus.init_busy, bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 1'b1, 3'(i), 7'h00}) begin
                failCount++; $display("[TB] FAIL sweep_%0d busy/we/addr/din got=%0h/%0h/%0h/%0h want=1/1/%0h/0", i, bus.init_busy, bus.ram_we, bus.ram_addr, bus.ram_din, i);
            end
        end
        nextCycle;
        checkCount++; if (bus.init_busy !== 1'b0) begin failCount++; $display("[TB] FAIL init_done_busy got=%0h want=0", bus.init_busy); end
        checkCount++; if (bus.ram_we !== 1'b0) begin failCount++; $display("[TB] FAIL idle_ram_we got=%0h want=0", bus.ram_we); end
        checkCount++; if (bus.ram_addr !== 3'd7) begin failCount++; $display("[TB] FAIL idle_addr_hold got=%0h want=7", bus.ram_addr); end
        for (int i = 0; i < 8; i++) begin
            checkCount++; if (mem[i] !== 7'h00) begin failCount++; $display("[TB] FAIL cleared_entry_%0d got=%0h want=0", i, mem[i]); end
        end
    endtask

    // Fill entry 5 with tag 0x2A, then look it up with matching and other tags.
    task automatic test_fill_lookup;
        nextCycle;
        applyStimulus(0, 0, 0, 1, 3'd5, 6'h2A, 1);
        checkCount++; if ({bus.fl_gnt, bus.lk_gnt} !== 2'b10) begin failCount++; $display("[TB] FAIL fill_gnt got=%0b want=10", {bus.fl_gnt, bus.lk_gnt}); end
        checkCount++; if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 3'd5, 7'h6A}) begin failCount++; $display("[TB] FAIL fill_bus got=%0h/%0h/%0h want=1/5/6a", bus.ram_we, bus.ram_addr, bus.ram_din); end
        nextCycle;
        applyStimulus(1, 3'd5, 6'h2A, 0, 0, 0, 0);
        checkCount++; if (mem[5] !== 7'h6A) begin failCount++; $display("[TB] FAIL fill_written got=%0h want=6a", mem[5]); end
        checkCount++; if ({bus.lk_gnt, bus.fl_gnt} !== 2'b10) begin failCount++; $display("[TB] FAIL lookup_gnt got=%0b want=10", {bus.lk_gnt, bus.fl_gnt}); end
        checkCount++; if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b0, 3'd5, 7'h00}) begin failCount++; $display("[TB] FAIL lookup_bus got=%0h/%0h/%0h want=0/5/0", bus.ram_we, bus.ram_addr, bus.ram_din); end
        checkCount++; if (bus.lk_done !== 1'b0) begin failCount++; $display("[TB] FAIL lookup_early_done got=%0h want=0", bus.lk_done); end
        nextCycle;
        applyStimulus(1, 3'd5, 6'h2B, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_done, bus.lk_hit} !== 2'b11) begin failCount++; $display("[TB] FAIL lookup_hit done/hit got=%0b want=11", {bus.lk_done, bus.lk_hit}); end
        checkCount++; if (bus.lk_gnt !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_gnt got=%0h want=1", bus.lk_gnt); end
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_done, bus.lk_hit} !== 2'b10) begin failCount++; $display("[TB] FAIL lookup_miss done/hit got=%0b want=10", {bus.lk_done, bus.lk_hit}); end
        checkCount++; if ({bus.ram_we, bus.ram_addr} !== {1'b0, 3'd5}) begin failCount++; $display("[TB] FAIL idle_hold got=%0h/%0h want=0/5", bus.ram_we, bus.ram_addr); end
        nextCycle;
        checkCount++; if ({bus.lk_done, bus.lk_hit} !== 2'b00) begin failCount++; $display("[TB] FAIL idle_done got=%0b want=00", {bus.lk_done, bus.lk_hit}); end
    endtask

    // Both requesters held for four cycles: fill, lookup, fill, lookup.
    task automatic test_conflict;
        for (int i = 0; i < 4; i++) begin
            nextCycle;
            applyStimulus(1, 3'd1, 6'h00, 1, 3'd2, 6'h05, 1);
            checkCount++; if ({bus.fl_gnt, bus.lk_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failCount++; $display("[TB] FAIL rr_cycle_%0d fl/lk got=%0b want=%0b", i, {bus.fl_gnt, bus.lk_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            checkCount++; if (bus.ram_addr !== ((i % 2 == 0) ? 3'd2 : 3'd1)) begin
                failCount++; $display("[TB] FAIL rr_addr_%0d got=%0h want=%0h", i, bus.ram_addr, (i % 2 == 0) ? 3'd2 : 3'd1);
            end
            checkCount++; if (bus.lk_done !== (i == 2)) begin
                failCount++; $display("[TB] FAIL rr_done_%0d got=%0h want=%0h", i, bus.lk_done, (i == 2));
            end
        end
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_done, bus.lk_hit, bus.fl_gnt} !== 3'b100) begin failCount++; $display("[TB] FAIL rr_tail done/hit/fl got=%0b want=100", {bus.lk_done, bus.lk_hit, bus.fl_gnt}); end
    endtask

    // Lookup then same-index fill: old entry reported; later lookup sees new tag.
    task automatic test_ordering;
        nextCycle;
        applyStimulus(1, 3'd3, 6'h11, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_gnt, bus.ram_addr} !== {1'b1, 3'd3}) begin failCount++; $display("[TB] FAIL ord_lk_gnt got=%0h/%0h want=1/3", bus.lk_gnt, bus.ram_addr); end
        nextCycle;
        applyStimulus(0, 0, 0, 1, 3'd3, 6'h11, 1);
        checkCount++; if ({bus.fl_gnt, bus.ram_din} !== {1'b1, 7'h51}) begin failCount++; $display("[TB] FAIL ord_fill got=%0h/%0h want=1/51", bus.fl_gnt, bus.ram_din); end
        checkCount++; if ({bus.lk_done, bus.lk_hit} !== 2'b10) begin failCount++; $display("[TB] FAIL ord_old_entry done/hit got=%0b want=10", {bus.lk_done, bus.lk_hit}); end
        nextCycle;
        applyStimulus(1, 3'd3, 6'h11, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_gnt, bus.lk_done} !== 2'b10) begin failCount++; $display("[TB] FAIL ord_relookup gnt/done got=%0b want=10", {bus.lk_gnt, bus.lk_done}); end
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_done, bus.lk_hit} !== 2'b11) begin failCount++; $display("[TB] FAIL ord_new_entry done/hit got=%0b want=11", {bus.lk_done, bus.lk_hit}); end
    endtask

    // Requests held through reset and the sweep are granted only once in RUN.
    task automatic test_init_requests;
        reset_n = 1'b0;
        applyStimulus(1, 3'd4, 6'h00, 1, 3'd4, 6'h3F, 1);
        checkCount++; if (bus.lk_done !== 1'b0) begin failCount++; $display("[TB] FAIL async_rst_done got=%0h want=0", bus.lk_done); end
        nextCycle;
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checkCount++; if ({bus.init_busy, bus.lk_gnt, bus.fl_gnt} !== 3'b100) begin
                failCount++; $display("[TB] FAIL init_nogrant_%0d busy/lk/fl got=%0b want=100", i, {bus.init_busy, bus.lk_gnt, bus.fl_gnt});
            end
            nextCycle;
        end
        checkCount++; if ({bus.init_busy, bus.fl_gnt, bus.lk_gnt} !== 3'b010) begin failCount++; $display("[TB] FAIL first_run busy/fl/lk got=%0b want=010", {bus.init_busy, bus.fl_gnt, bus.lk_gnt}); end
        checkCount++; if ({bus.ram_addr, bus.ram_din} !== {3'd4, 7'h7F}) begin failCount++; $display("[TB] FAIL first_run_bus got=%0h/%0h want=4/7f", bus.ram_addr, bus.ram_din); end
        nextCycle;
        applyStimulus(1, 3'd4, 6'h00, 0, 0, 0, 0);
        checkCount++; if (bus.lk_gnt !== 1'b1) begin failCount++; $display("[TB] FAIL second_run_lk got=%0h want=1", bus.lk_gnt); end
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkCount++; if ({bus.lk_done, bus.lk_hit} !== 2'b10) begin failCount++; $display("[TB] FAIL init_lookup done/hit got=%0b want=10", {bus.lk_done, bus.lk_hit}); end
    endtask

    // Reset drops a pending lk_done, and a reset mid-sweep restarts at entry 0.
    task automatic test_reset_mid;
        nextCycle;
        applyStimulus(1, 3'd2, 6'h00, 0, 0, 0, 0);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkCount++; if (bus.lk_done !== 1'b1) begin failCount++; $display("[TB] FAIL pre_rst_done got=%0h want=1", bus.lk_done); end
        reset_n = 1'b0;
        #1;
        checkCount++; if ({bus.lk_done, bus.init_busy, bus.ram_addr} !== {1'b0, 1'b1, 3'd0}) begin failCount++; $display("[TB] FAIL rst_drop done/busy/addr got=%0h/%0h/%0h want=0/1/0", bus.lk_done, bus.init_busy, bus.ram_addr); end
        nextCycle;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) nextCycle;
        checkCount++; if ({bus.ram_we, bus.ram_addr} !== {1'b1, 3'd4}) begin failCount++; $display("[TB] FAIL sweep_at_4 got=%0h/%0h want=1/4", bus.ram_we, bus.ram_addr); end
        reset_n = 1'b0;
        #1;
        checkCount++; if ({bus.ram_we, bus.ram_addr, bus.init_busy} !== {1'b0, 3'd0, 1'b1}) begin failCount++; $display("[TB] FAIL mid_rst we/addr/busy got=%0h/%0h/%0h want=0/0/1", bus.ram_we, bus.ram_addr, bus.init_busy); end
        nextCycle;
        reset_n = 1'b1;
        nextCycle;
        checkCount++; if ({bus.ram_we, bus.ram_addr} !== {1'b1, 3'd0}) begin failCount++; $display("[TB] FAIL sweep_restart got=%0h/%0h want=1/0", bus.ram_we, bus.ram_addr); end
        repeat (8) nextCycle;
        checkCount++; if (bus.init_busy !== 1'b0) begin failCount++; $display("[TB] FAIL restart_done_busy got=%0h want=0", bus.init_busy); end
        applyStimulus(1, 3'd6, 6'h00, 1, 3'd6, 6'h15, 1);
        checkCount++; if ({bus.fl_gnt, bus.lk_gnt} !== 2'b10) begin failCount++; $display("[TB] FAIL rr_after_rst fl/lk got=%0b want=10", {bus.fl_gnt, bus.lk_gnt}); end
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

`ifdef TAG_ARB_STATS_EN
    // Three hits and two misses, then a clear.
    task automatic test_stats;
        checkCount++; if ({bus.hit_cnt, bus.miss_cnt} !== 32'h0) begin failCount++; $display("[TB] FAIL stats_reset got=%0h/%0h want=0/0", bus.hit_cnt, bus.miss_cnt); end
        nextCycle; applyStimulus(1, 3'd6, 6'h15, 0, 0, 0, 0);
        nextCycle; applyStimulus(1, 3'd6, 6'h15, 0, 0, 0, 0);
        nextCycle; applyStimulus(1, 3'd6, 6'h15, 0, 0, 0, 0);
        nextCycle; applyStimulus(1, 3'd6, 6'h16, 0, 0, 0, 0);
        nextCycle; applyStimulus(1, 3'd0, 6'h00, 0, 0, 0, 0);
        nextCycle; applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle;
        checkCount++; if (bus.hit_cnt !== 16'd3) begin failCount++; $display("[TB] FAIL hit_cnt got=%0d want=3", bus.hit_cnt); end
        checkCount++; if (bus.miss_cnt !== 16'd2) begin failCount++; $display("[TB] FAIL miss_cnt got=%0d want=2", bus.miss_cnt); end
        bus.stats_clr = 1'b1;
        nextCycle;
        bus.stats_clr = 1'b0;
        checkCount++; if ({bus.hit_cnt, bus.miss_cnt} !== 32'h0) begin failCount++; $display("[TB] FAIL stats_clr got=%0h/%0h want=0/0", bus.hit_cnt, bus.miss_cnt); end
    endtask
`endif

    // Scenario sequence and the summary line.
    initial begin
`ifdef TAG_ARB_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        test_reset;
        test_fill_lookup;
        test_conflict;
        test_ordering;
        test_init_requests;
        test_reset_mid;
`ifdef TAG_ARB_STATS_EN
        test_stats;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
